// File: rtl/rv_pipe_pkg.sv
// Shared types and constants for the RISC-V pipeline stages.
// Used by instruction_fetch_stage and pc_next_sel.
package rv_pipe_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  // addi x0,x0,0
  localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP  = 64'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_SEL_HOLD   = 2'd0,
    PC_SEL_INC    = 2'd1,
    PC_SEL_REDIR  = 2'd2,
    PC_SEL_TARGET = 2'd3
  } pc_sel_t;

endpackage

// File: rtl/instruction_fetch_stage_pc_next_sel.sv
// Next-PC multiplexer and redirect alignment check for the fetch stage.
// IF_MISALIGN_TRAP_EN keeps the raw redirect target and flags misalignment.
module pc_next_sel
  import rv_pipe_pkg::*;
(
  input  pc_sel_t         sel,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic [XLEN-1:0] target,
`ifdef IF_MISALIGN_TRAP_EN
  output logic            misaligned,
`endif
  output logic [XLEN-1:0] redirect_eff,
  output logic [XLEN-1:0] pc_next
);

  // Redirect target conditioning
  always_comb begin
`ifdef IF_MISALIGN_TRAP_EN
    redirect_eff = redirect_pc;
    misaligned   = (redirect_pc[1:0] != 2'b00);
`else
    redirect_eff = redirect_pc & ~64'h0000_0000_0000_0003;
`endif
  end

  // Next-PC selection; +4 wraps modulo 2^64
  always_comb begin
    pc_next = pc;
    case (sel)
      PC_SEL_HOLD:   pc_next = pc;
      PC_SEL_INC:    pc_next = pc + PC_STEP;
      PC_SEL_REDIR:  pc_next = redirect_eff;
      PC_SEL_TARGET: pc_next = target;
      default:       pc_next = pc;
    endcase
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, runs the imem req/ack handshake, handles stall/redirect.
// Optional misaligned-redirect trap enabled by defining IF_MISALIGN_TRAP_EN.
module instruction_fetch_stage
  import rv_pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 64'h0,
  parameter logic [ILEN-1:0] NOP_INST = rv_pipe_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_rdata,
  output logic [ILEN-1:0] instruction,
  output logic [XLEN-1:0] PC_out,
`ifdef IF_MISALIGN_TRAP_EN
  output logic            fetch_misalign,
`endif
  output logic            fetch_valid
);

  fetch_state_t    state_r;
  fetch_state_t    state_n_s;
  pc_sel_t         pc_sel_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_next_s;
  logic [XLEN-1:0] target_r;
  logic [XLEN-1:0] redirect_eff_s;
  logic [ILEN-1:0] hold_data_r;
  logic [ILEN-1:0] deliver_data_s;
  logic            deliver_s;
  logic            park_s;
  logic            latch_s;
  logic            req_s;
  logic            trap_block_s;
  logic [ILEN-1:0] instruction_r;
  logic [XLEN-1:0] pc_out_r;
  logic            fetch_valid_r;

`ifdef IF_MISALIGN_TRAP_EN
  logic            misaligned_s;
  logic            misalign_r;

  assign trap_block_s   = misalign_r;
  assign fetch_misalign = misalign_r;
`else
  assign trap_block_s   = 1'b0;
`endif

  pc_next_sel u_pc_next_sel (
    .sel          (pc_sel_s),
    .pc           (pc_r),
    .redirect_pc  (redirect_pc),
    .target       (target_r),
`ifdef IF_MISALIGN_TRAP_EN
    .misaligned   (misaligned_s),
`endif
    .redirect_eff (redirect_eff_s),
    .pc_next      (pc_next_s)
  );

  // A trapped misaligned redirect parks the stage in IDLE with no request
  assign req_s = ((state_r == IDLE) && !stall && !redirect_valid && !trap_block_s)
               || (state_r == BUSY) || (state_r == DROP);

  assign imem_req    = req_s;
  assign imem_addr   = pc_r;
  assign instruction = instruction_r;
  assign PC_out      = pc_out_r;
  assign fetch_valid = fetch_valid_r;

  // Next-state and datapath control decode
  always_comb begin
    state_n_s      = state_r;
    pc_sel_s       = PC_SEL_HOLD;
    deliver_s      = 1'b0;
    deliver_data_s = imem_rdata;
    park_s         = 1'b0;
    latch_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (redirect_valid) begin
          pc_sel_s = PC_SEL_REDIR;
        end else if (req_s && imem_ack) begin
          deliver_s = 1'b1;
          pc_sel_s  = PC_SEL_INC;
        end else if (req_s) begin
          state_n_s = BUSY;
        end else begin
          state_n_s = IDLE;
        end
      end
      BUSY: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            pc_sel_s  = PC_SEL_REDIR;
            state_n_s = IDLE;
          end else if (stall) begin
            park_s    = 1'b1;
            state_n_s = HOLD;
          end else begin
            deliver_s = 1'b1;
            pc_sel_s  = PC_SEL_INC;
            state_n_s = IDLE;
          end
        end else if (redirect_valid) begin
          latch_s   = 1'b1;
          state_n_s = DROP;
        end else begin
          state_n_s = BUSY;
        end
      end
      DROP: begin
        // A redirect coinciding with the ack wins over the latched target
        if (imem_ack) begin
          pc_sel_s  = redirect_valid ? PC_SEL_REDIR : PC_SEL_TARGET;
          state_n_s = IDLE;
        end else if (redirect_valid) begin
          latch_s   = 1'b1;
          state_n_s = DROP;
        end else begin
          state_n_s = DROP;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_sel_s  = PC_SEL_REDIR;
          state_n_s = IDLE;
        end else if (!stall) begin
          deliver_s      = 1'b1;
          deliver_data_s = hold_data_r;
          pc_sel_s       = PC_SEL_INC;
          state_n_s      = IDLE;
        end else begin
          state_n_s = HOLD;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // State, PC, latched redirect target and parked word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      pc_r        <= RESET_PC;
      target_r    <= RESET_PC;
      hold_data_r <= NOP_INST;
    end else begin
      state_r <= state_n_s;
      pc_r    <= pc_next_s;
      if (latch_s) begin
        target_r <= redirect_eff_s;
      end else begin
        target_r <= target_r;
      end
      if (park_s) begin
        hold_data_r <= imem_rdata;
      end else begin
        hold_data_r <= hold_data_r;
      end
    end
  end

  // Registered outputs to IF/ID; a flush overrides a stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instruction_r <= NOP_INST;
      pc_out_r      <= 64'h0;
      fetch_valid_r <= 1'b0;
    end else if (redirect_valid) begin
      instruction_r <= NOP_INST;
      fetch_valid_r <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
      if (misaligned_s) begin
        pc_out_r <= redirect_eff_s;
      end else begin
        pc_out_r <= pc_out_r;
      end
`else
      pc_out_r      <= pc_out_r;
`endif
    end else if (stall) begin
      instruction_r <= instruction_r;
      pc_out_r      <= pc_out_r;
      fetch_valid_r <= fetch_valid_r;
    end else if (deliver_s) begin
      instruction_r <= deliver_data_s;
      pc_out_r      <= pc_r;
      fetch_valid_r <= 1'b1;
    end else begin
      instruction_r <= NOP_INST;
      pc_out_r      <= pc_out_r;
      fetch_valid_r <= 1'b0;
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  // Misalignment flag tracks the most recent redirect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_r <= 1'b0;
    end else if (redirect_valid) begin
      misalign_r <= misaligned_s;
    end else begin
      misalign_r <= misalign_r;
    end
  end
`endif

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Fetch stage of the 5-stage RISC-V pipeline, directly upstream of the IF/ID pipeline register. It owns the 64-bit program counter and runs a req/ack handshake with instruction memory. Each returned word is presented, with its PC, on `instruction`/`PC_out` for IF/ID to capture. It also handles downstream stall, branch/jump redirect, and flushing of in-flight fetches.

## Interface
- `RESET_PC`, default 64'h0: PC value loaded on reset.
- `NOP_INST`, default 32'h00000013: `addi x0,x0,0`, driven on `instruction` for bubbles.
- `clk`  in  1  pipeline clock.
- `reset`  in  1  asynchronous, active-low reset.
- `stall`  in  1  downstream cannot accept; outputs must hold.
- `redirect_valid`  in  1  branch/jump taken this cycle.
- `redirect_pc`  in  64  redirect target.
- `imem_req`  out  1  fetch request; held high until `imem_ack`.
- `imem_addr`  out  64  fetch address; stable while `imem_req` is high.
- `imem_ack`  in  1  `imem_rdata` is valid this cycle; may arrive the same cycle as `imem_req`.
- `imem_rdata`  in  32  fetched word.
- `instruction`  out  32  instruction to IF/ID.
- `PC_out`  out  64  PC of `instruction`.
- `fetch_valid`  out  1  `instruction` is real, not a bubble.
- `fetch_misalign`  out  1  misaligned redirect flag. Present only with `IF_MISALIGN_TRAP_EN`.

## Operation
- States: IDLE (nothing outstanding), BUSY (request outstanding), DROP (outstanding request whose data will be discarded), HOLD (one word parked while stalled).
- `imem_addr` = `pc` in all states. `imem_req` = (IDLE & !stall & !redirect_valid) | BUSY | DROP.
- Deliver: `instruction`<=`imem_rdata`, `PC_out`<=`pc`, `fetch_valid`<=1, `pc`<=`pc`+4 (mod 2^64, wraps silently).
- IDLE:
  - req & ack: deliver, stay in IDLE.
  - req & !ack: go to BUSY.
  - redirect: `pc`<=`redirect_pc`.
- BUSY:
  - ack & redirect: discard the word, `pc`<=`redirect_pc`, go to IDLE.
  - ack & stall: park the word in the hold buffer, go to HOLD.
  - ack otherwise: deliver, go to IDLE.
  - !ack & redirect: latch the target, go to DROP.
- DROP:
  - ack: discard the word, `pc`<=latched target, go to IDLE.
  - A further redirect overwrites the latched target. If that redirect lands in the ack cycle, the new target is used.
- HOLD:
  - redirect: discard the parked word, `pc`<=target, go to IDLE.
  - else if !stall: deliver the parked word, go to IDLE.
- Output update rules:
  - Any cycle with `redirect_valid`: `fetch_valid`<=0 and `instruction`<=`NOP_INST`. Flush beats stall.
  - Otherwise, if `stall`: outputs hold.
  - Otherwise, if no deliver: `fetch_valid`<=0, `instruction`<=`NOP_INST`, `PC_out` holds.
- Reset (asserted at any time, including mid-transaction):
  - `pc`=`RESET_PC`, state=IDLE, `instruction`=`NOP_INST`, `PC_out`=0, `fetch_valid`=0, `fetch_misalign`=0.
  - Any outstanding memory response after reset release is undefined. Memory is reset together with this block.

## Timing
- Zero-wait memory: req in cycle N, ack in cycle N; outputs are valid after edge N+1. Throughput is 1 instruction per cycle.
- k wait cycles: outputs are valid k+1 edges after req first rises.
- Redirect in cycle N: `fetch_valid`=0 after edge N+1. First fetch from the target is requested in cycle N+1 (IDLE) or in the cycle after the DROP ack.
- Stall released in HOLD at cycle N: the parked word appears after edge N+1, and a new request starts in cycle N+1.
- All outputs are registered except `imem_req`/`imem_addr`, which are combinational from state, `pc`, `stall` and `redirect_valid`.

## Configuration
- `IF_MISALIGN_TRAP_EN` defined:
  - A redirect with `redirect_pc[1:0]`!=0 sets `fetch_misalign`<=1 and `PC_out`<=target, and the block stays in IDLE with `imem_req`=0.
  - It clears only on the next aligned redirect or on reset.
- Not defined: `redirect_pc[1:0]` is forced to 2'b00 and the `fetch_misalign` port is absent.

## Structure
- Shared package `rv_pipe_pkg` holds:
  - `XLEN`=64 and `ILEN`=32;
  - `NOP_INST` constant;
  - `fetch_state_t` enum {IDLE, BUSY, DROP, HOLD}.
- One sub-module, `pc_next_sel`: combinational next-pc mux over {hold, +4, redirect, latched target}, plus the alignment check.

## Test plan
- Reset with `RESET_PC`=64'h1000, zero-wait memory, words 0xA,0xB,0xC: `imem_addr` reads 1000,1004,1008. Output pairs (`instruction`,`PC_out`) are (A,1000),(B,1004),(C,1008) on consecutive cycles with `fetch_valid`=1.
- 2-cycle memory latency: `imem_req` holds high with `imem_addr` stable for 3 cycles, and `fetch_valid` pulses once per word.
- `stall` high while BUSY, ack arrives: state goes to HOLD and outputs hold. Release: parked word appears the next cycle with the correct PC and nothing is duplicated.
- Redirect to 0x2000 while BUSY (no ack): the stale ack data never reaches the outputs. Next `imem_addr`=0x2000, and `fetch_valid`=0 in between.
- Redirect and stall in the same cycle: `fetch_valid`=0 and `instruction`=0x13 on the next edge.
- Reset asserted mid-BUSY: all outputs return to their reset values asynchronously. With `IF_MISALIGN_TRAP_EN`, a redirect to 0x2002 gives `fetch_misalign`=1 and `imem_req`=0.
